// File: rtl/bsg_counter_window_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bsg_counter_window_ctrl                                                |
// | Sequences an external clear/up counter through fixed-length windows    |
// | and hands each captured count to a valid/yumi consumer.                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module bsg_counter_window_ctrl #(
  parameter int width_p        = 32,
  parameter int window_width_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      continuous_i,
  input  logic [window_width_p-1:0] window_i,
  input  logic                      event_i,
  output logic                      ctr_clear_o,
  output logic                      ctr_up_o,
  input  logic [width_p-1:0]        ctr_count_i,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic                      busy_o
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_run     = 2'd1;
  localparam logic [1:0] c_capture = 2'd2;
  localparam logic [1:0] c_report  = 2'd3;

  localparam logic [window_width_p-1:0] c_one = window_width_p'(1);

  // A window longer than the counter could let the count wrap silently.
  if (window_width_p > width_p) begin : g_width_check
    $error("window_width_p must not exceed width_p");
  end

  logic [1:0]                state_r;
  logic [1:0]                state_n;
  logic [window_width_p-1:0] window_r;
  logic [window_width_p-1:0] remaining_r;
  logic [window_width_p-1:0] remaining_n;
  logic [width_p-1:0]        data_r;
  logic                      v_r;
  logic                      busy_r;
  logic                      window_load;
  logic                      capture_en;
  logic                      clear_n;
  logic                      up_n;

  always_comb begin
    state_n     = state_r;
    remaining_n = remaining_r;
    window_load = 1'b0;
    capture_en  = 1'b0;
    clear_n     = 1'b0;
    up_n        = 1'b0;
    case (state_r)
      c_idle: begin
        if (start_i && !stop_i && (window_i != '0)) begin
          state_n     = c_run;
          clear_n     = 1'b1;
          window_load = 1'b1;
          remaining_n = window_i;
        end
      end
      c_run: begin
        if (stop_i) begin
          state_n = c_idle;
          clear_n = 1'b1;
        end else begin
          up_n        = event_i;
          remaining_n = remaining_r - c_one;
          if (remaining_r == c_one) begin
            state_n = c_capture;
          end
        end
      end
      c_capture: begin
        if (stop_i) begin
          state_n = c_idle;
          clear_n = 1'b1;
        end else begin
          capture_en = 1'b1;
          state_n    = c_report;
        end
      end
      c_report: begin
        if (stop_i) begin
          state_n = c_idle;
          clear_n = 1'b1;
        end else if (yumi_i) begin
          if (continuous_i) begin
            state_n     = c_run;
            clear_n     = 1'b1;
            remaining_n = window_r;
          end else begin
            state_n = c_idle;
          end
        end
      end
      default: begin
        state_n = c_idle;
      end
    endcase
  end

  // Gated by reset so the counter sees no strobes while reset is held.
  assign ctr_clear_o = clear_n & ~reset_i;
  assign ctr_up_o    = up_n & ~reset_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= c_idle;
      remaining_r <= '0;
      window_r    <= '0;
      data_r      <= '0;
      v_r         <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      remaining_r <= remaining_n;
      if (window_load) begin
        window_r <= window_i;
      end
      if (capture_en) begin
        data_r <= ctr_count_i;
      end
      v_r    <= (state_n == c_report);
      busy_r <= (state_n != c_idle);
    end
  end

  assign v_o    = v_r;
  assign data_o = data_r;
  assign busy_o = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_bsg_counter_window_ctrl.sv
`default_nettype none
// Bench for bsg_counter_window_ctrl with a behavioural clear/up counter and
// a queue-based scoreboard checked by an independent output monitor.
module tb_bsg_counter_window_ctrl;

  localparam int W  = 32;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          continuous_i = 1'b0;
  logic [WW-1:0] window_i = '0;
  logic          event_i = 1'b0;
  logic          yumi_i = 1'b0;
  logic          ctr_clear_o;
  logic          ctr_up_o;
  logic [W-1:0]  ctr_count;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  bsg_counter_window_ctrl #(.width_p(W), .window_width_p(WW)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .window_i(window_i), .event_i(event_i),
    .ctr_clear_o(ctr_clear_o), .ctr_up_o(ctr_up_o), .ctr_count_i(ctr_count),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .busy_o(busy_o)
  );

  // Stand-in for the attached bsg_counter_clear_up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ctr_count <= '0;
    else if (ctr_clear_o) ctr_count <= '0;
    else if (ctr_up_o)    ctr_count <= ctr_count + 1'b1;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per result and checks stability while held.
  initial begin
    logic         v_prev;
    logic [W-1:0] held;
    v_prev = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        v_prev = 1'b0;
      end else begin
        if (v_o && !v_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_v", 32'd1, 32'd0);
          end else begin
            chk("sb_data", data_o, exp_q.pop_front());
          end
          held = data_o;
        end else if (v_o) begin
          chk("data_stable", data_o, held);
        end
        v_prev = v_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input int lim, output int c);
    c = 0;
    while (!v_o && c < lim) begin
      tick();
      c++;
    end
  endtask

  task automatic start_win(input logic [WW-1:0] w);
    start_i  = 1'b1;
    window_i = w;
    #1;
    chk("clr_on_start", {31'd0, ctr_clear_o}, 32'd1);
    tick();
    start_i = 1'b0;
  endtask

  task automatic take(input logic cont);
    yumi_i       = 1'b1;
    continuous_i = cont;
    tick();
    yumi_i = 1'b0;
  endtask

  initial begin
    int c;
    logic seen;
    logic [4:0] pat;

    // Reset state
    tick(); tick();
    chk("rst_outs", {27'd0, v_o, busy_o, ctr_clear_o, ctr_up_o, 1'b0}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst = 1'b0;
    tick();

    // W=4, events held high: v_o in cycle 6 with 4
    exp_q.push_back(32'd4);
    event_i = 1'b1;
    start_win(16'd4);
    wait_v(30, c);
    chk("lat_w4", c, 32'd5);
    take(1'b0);
    chk("idle_after_yumi", {30'd0, busy_o, v_o}, 32'd0);

    // W=5, events 1,0,1,0,1
    exp_q.push_back(32'd3);
    pat = 5'b10101;
    event_i = 1'b0;
    start_i = 1'b1; window_i = 16'd5;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      event_i = pat[i];
      tick();
    end
    event_i = 1'b1;
    wait_v(30, c);
    take(1'b0);

    // W=1 gives v_o in cycle 3
    exp_q.push_back(32'd1);
    start_win(16'd1);
    wait_v(30, c);
    chk("lat_w1", c, 32'd2);
    take(1'b0);

    // Zero window is ignored
    start_i = 1'b1; window_i = 16'd0;
    #1;
    chk("w0_noclr", {31'd0, ctr_clear_o}, 32'd0);
    tick();
    start_i = 1'b0;
    chk("w0_busy", {31'd0, busy_o}, 32'd0);

    // Backpressure with start pulses during REPORT
    exp_q.push_back(32'd3);
    start_win(16'd3);
    wait_v(30, c);
    seen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start_i  = i[0];
      window_i = 16'd7;
      tick();
      seen = seen & v_o;
    end
    start_i = 1'b0;
    chk("bp_v_held", {31'd0, seen}, 32'd1);
    take(1'b0);

    // Continuous: one result every 5 cycles
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd3);
    start_win(16'd3);
    wait_v(30, c);
    chk("cont_first", c, 32'd4);
    take(1'b1);
    wait_v(30, c);
    chk("cont_period1", c, 32'd4);
    take(1'b1);
    wait_v(30, c);
    chk("cont_period2", c, 32'd4);
    take(1'b0);
    chk("cont_end_busy", {31'd0, busy_o}, 32'd0);

    // Stop in 2nd RUN cycle
    start_win(16'd4);
    tick();
    stop_i = 1'b1;
    #1;
    chk("stop_clr", {30'd0, ctr_clear_o, ctr_up_o}, 32'd2);
    tick();
    stop_i = 1'b0;
    chk("stop_idle", {31'd0, busy_o}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | v_o;
    end
    chk("stop_no_v", {31'd0, seen}, 32'd0);

    // Stop together with yumi in REPORT: no rearm
    exp_q.push_back(32'd3);
    continuous_i = 1'b1;
    start_win(16'd3);
    wait_v(30, c);
    stop_i = 1'b1; yumi_i = 1'b1;
    #1;
    chk("stopy_clr", {31'd0, ctr_clear_o}, 32'd1);
    tick();
    stop_i = 1'b0; yumi_i = 1'b0; continuous_i = 1'b0;
    chk("stopy_idle", {30'd0, busy_o, v_o}, 32'd0);
    tick(); tick();
    chk("stopy_still_idle", {31'd0, busy_o}, 32'd0);

    // Async reset mid-RUN
    start_win(16'd6);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_run", {28'd0, v_o, busy_o, ctr_clear_o, ctr_up_o}, 32'd0);
    tick();
    rst = 1'b0;

    // Async reset mid-REPORT
    exp_q.push_back(32'd2);
    start_win(16'd2);
    wait_v(30, c);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_rep", {28'd0, v_o, busy_o, ctr_clear_o, ctr_up_o}, 32'd0);
    chk("arst_rep_data", data_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Recovery: W=3, events 1,1,0 -> 2
    exp_q.push_back(32'd2);
    start_i = 1'b1; window_i = 16'd3;
    tick();
    start_i = 1'b0;
    event_i = 1'b1; tick();
    event_i = 1'b1; tick();
    event_i = 1'b0; tick();
    wait_v(30, c);
    take(1'b0);

    tick(); tick();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
